// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: the pipeline (master) supplies register
// and memory status, the hazard unit (slave) returns forwarding, stall and flush controls.
interface hazard_ctrl_if;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic [4:0]  rs1_e;
  logic [4:0]  rs2_e;
  logic [4:0]  rd_e;
  logic [1:0]  result_src_e;
  logic        pc_src_e;
  logic [4:0]  rd_m;
  logic [4:0]  rd_w;
  logic        reg_write_m;
  logic        reg_write_w;
  logic        mem_req_m;
  logic        mem_ack;
  logic [1:0]  forward_a_e;
  logic [1:0]  forward_b_e;
  logic        stall_f;
  logic        stall_d;
  logic        stall_e;
  logic        stall_m;
  logic        flush_d;
  logic        flush_e;
  logic        flush_w;
  logic        mem_wait;
  logic        mem_err;
  logic [15:0] stall_cycles;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e, pc_src_e,
    output rd_m, rd_w, reg_write_m, reg_write_w, mem_req_m, mem_ack,
    input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_w, mem_wait, mem_err, stall_cycles
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e, pc_src_e,
    input  rd_m, rd_w, reg_write_m, reg_write_w, mem_req_m, mem_ack,
    output forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_w, mem_wait, mem_err, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use stall,
// branch flush and a data-memory wait FSM with ack timeout.
module hazard_ctrl #(
  parameter int unsigned          CNT_WIDTH   = 8,
  parameter logic [CNT_WIDTH-1:0] MEM_TIMEOUT = CNT_WIDTH'(200)
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [0:0]           r_state;
  logic [CNT_WIDTH-1:0] r_wait_cnt;
  logic                 r_mem_wait;
  logic [15:0]          r_stall_cycles;

  logic [0:0] w_state;
  logic [0:0] w_next_state;
  logic       w_timeout_hit;
  logic       w_mem_stall;
  logic       w_lw_stall;
  logic       w_mem_err;
  logic       w_stall_f;
  logic       w_stall_d;
  logic       w_stall_e;
  logic       w_stall_m;
  logic       w_flush_d;
  logic       w_flush_e;
  logic       w_flush_w;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wr_m,
    input logic [4:0] rd_m,
    input logic       wr_w,
    input logic [4:0] rd_w
  );
    logic [1:0] sel;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // While reset is held the combinational outputs behave as if the FSM were idle.
  assign w_state       = rst ? S_IDLE : r_state;
  assign w_timeout_hit = (w_state == S_WAIT) && (r_wait_cnt == MEM_TIMEOUT);
  assign w_mem_err     = w_timeout_hit && !hz.mem_ack;
  assign w_mem_stall   = ((w_state == S_IDLE) && hz.mem_req_m && !hz.mem_ack) ||
                         ((w_state == S_WAIT) && !hz.mem_ack && !w_timeout_hit);
  assign w_lw_stall    = (hz.result_src_e == 2'b01) && (hz.rd_e != 5'd0) &&
                         ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

  // Memory wait FSM next-state selection.
  always_comb begin
    w_next_state = S_IDLE;
    case (w_state)
      S_IDLE: begin
        if (hz.mem_req_m && !hz.mem_ack) begin
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (hz.mem_ack || w_timeout_hit) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // A memory stall freezes the whole front end, so a pending branch flush waits for it.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    if (w_mem_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
    end else if (w_lw_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
      w_flush_d = hz.pc_src_e;
    end else begin
      w_flush_d = hz.pc_src_e;
      w_flush_e = hz.pc_src_e;
    end
  end

  // FSM state, wait counter, mem_wait flag and stall statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_wait_cnt     <= {CNT_WIDTH{1'b0}};
      r_mem_wait     <= 1'b0;
      r_stall_cycles <= 16'd0;
    end else begin
      r_state    <= w_next_state;
      r_mem_wait <= (w_next_state == S_WAIT);
      if ((r_state == S_WAIT) && (w_next_state == S_WAIT)) begin
        if (r_wait_cnt != CNT_MAX) begin
          r_wait_cnt <= r_wait_cnt + CNT_WIDTH'(1);
        end else begin
          r_wait_cnt <= r_wait_cnt;
        end
      end else begin
        r_wait_cnt <= {CNT_WIDTH{1'b0}};
      end
      if (w_stall_f && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end else begin
        r_stall_cycles <= r_stall_cycles;
      end
    end
  end

  assign hz.forward_a_e  = fwd_sel(hz.rs1_e, hz.reg_write_m, hz.rd_m, hz.reg_write_w, hz.rd_w);
  assign hz.forward_b_e  = fwd_sel(hz.rs2_e, hz.reg_write_m, hz.rd_m, hz.reg_write_w, hz.rd_w);
  assign hz.stall_f      = w_stall_f;
  assign hz.stall_d      = w_stall_d;
  assign hz.stall_e      = w_stall_e;
  assign hz.stall_m      = w_stall_m;
  assign hz.flush_d      = w_flush_d;
  assign hz.flush_e      = w_flush_e;
  assign hz.flush_w      = w_flush_w;
  assign hz.mem_wait     = r_mem_wait;
  assign hz.mem_err      = w_mem_err;
  assign hz.stall_cycles = r_stall_cycles;

endmodule
